// File: rtl/data_bus_unit_pkg.sv
// Shared encodings and helpers for the data-side bus unit.
package data_bus_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  localparam int unsigned DATA_BUS_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } dbu_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } dbu_req_t;

  function automatic logic [3:0] lane_strobe(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] s;
    s = 4'b0000;
    unique case (1'b1)
      size == SIZE_BYTE: s = 4'b0001 << off;
      size == SIZE_HALF: s = off[1] ? 4'b1100 : 4'b0011;
      size == SIZE_WORD: s = 4'b1111;
      default:           s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_replicate(
    input logic [1:0]  size,
    input logic [31:0] data
  );
    logic [31:0] r;
    r = data;
    unique case (1'b1)
      size == SIZE_BYTE: r = {4{data[7:0]}};
      size == SIZE_HALF: r = {2{data[15:0]}};
      default:           r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_bus_unit_load_formatter.sv
// Lane select and sign/zero extension of a bus read word.
module load_formatter
  import data_bus_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{offset_i, 3'b000} +: 8];
    half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = word_i;
    unique case (1'b1)
      size_i == SIZE_BYTE:
        data_o = {{24{signed_i & byte_v[7]}}, byte_v};
      size_i == SIZE_HALF:
        data_o = {{16{signed_i & half_v[15]}}, half_v};
      default:
        data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_bus_unit.sv
// Memory-stage data bus responder: one word-aligned valid/ready access.
// Define DATA_BUS_FAULT_EN to add ext_error input and mem_fault output.
module data_bus_unit
  import data_bus_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = DATA_BUS_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        mem_load,
  input  logic        mem_store,
  output logic [31:0] mem_load_data,
  output logic        mem_busy,
  output logic [29:0] ext_address,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_strobe,
  output logic        ext_write,
  output logic        ext_valid,
  input  logic        ext_ready,
  input  logic [31:0] ext_read_data
`ifdef DATA_BUS_FAULT_EN
  ,
  input  logic        ext_error,
  output logic        mem_fault
`endif
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  dbu_state_e  state_q, state_d;
  dbu_req_t    req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] fmt_data;
  logic        new_req;
  logic        in_req;
  logic        in_done;
  logic        bus_err;

`ifdef DATA_BUS_FAULT_EN
  logic fault_q, fault_d;
  assign bus_err = ext_error;
`else
  assign bus_err = 1'b0;
`endif

  assign new_req = (mem_load | mem_store) && (mem_size != SIZE_NONE);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    mem_busy  = 1'b0;
    ext_valid = 1'b0;
`ifdef DATA_BUS_FAULT_EN
    fault_d   = fault_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (new_req) begin
          mem_busy    = 1'b1;
          req_d.addr  = mem_address;
          req_d.size  = mem_size;
          req_d.sgn   = mem_signed;
          req_d.wr    = mem_store;
          req_d.strb  = mem_store ?
            lane_strobe(mem_size, mem_address[1:0]) : 4'b0000;
          req_d.wdata = lane_replicate(mem_size, mem_store_data);
          state_d     = ST_REQ;
`ifdef DATA_BUS_FAULT_EN
          fault_d     = 1'b0;
`endif
        end
      end
      ST_REQ: begin
        mem_busy  = 1'b1;
        ext_valid = 1'b1;
        if (ext_ready) begin
          rdata_d = ext_read_data;
          cnt_d   = '0;
          state_d = ST_DONE;
`ifdef DATA_BUS_FAULT_EN
          fault_d = bus_err;
`endif
        end else if (cnt_q + 16'd1 == TMO) begin
          // Abandon the access; the stage sees zero data.
          rdata_d = '0;
          cnt_d   = '0;
          state_d = ST_DONE;
`ifdef DATA_BUS_FAULT_EN
          fault_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
`ifdef DATA_BUS_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef DATA_BUS_FAULT_EN
      fault_q <= fault_d;
`endif
    end
  end

  load_formatter u_fmt (
    .word_i   (rdata_q),
    .offset_i (req_q.addr[1:0]),
    .size_i   (req_q.size),
    .signed_i (req_q.sgn),
    .data_o   (fmt_data)
  );

  assign in_req  = (state_q == ST_REQ);
  assign in_done = (state_q == ST_DONE);

  assign ext_address    = in_req ? req_q.addr[31:2] : '0;
  assign ext_write_data = in_req ? req_q.wdata : '0;
  assign ext_strobe     = in_req ? req_q.strb : '0;
  assign ext_write      = in_req & req_q.wr;

  assign mem_load_data = (in_done && !req_q.wr) ? fmt_data : '0;

`ifdef DATA_BUS_FAULT_EN
  assign mem_fault = in_done & fault_q;
`endif

  logic unused_err;
  assign unused_err = bus_err;

endmodule

// File: tb/tb_data_bus_unit.sv
// Self-checking bench for data_bus_unit against a behavioural model.
module tb_data_bus_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_address;
  logic [31:0] mem_store_data;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic        mem_load;
  logic        mem_store;
  logic [31:0] mem_load_data;
  logic        mem_busy;
  logic [29:0] ext_address;
  logic [31:0] ext_write_data;
  logic [3:0]  ext_strobe;
  logic        ext_write;
  logic        ext_valid;
  logic        ext_ready;
  logic [31:0] ext_read_data;
`ifdef DATA_BUS_FAULT_EN
  logic        ext_error;
  logic        mem_fault;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_bus_unit #(.TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_address    (mem_address),
    .mem_store_data (mem_store_data),
    .mem_size       (mem_size),
    .mem_signed     (mem_signed),
    .mem_load       (mem_load),
    .mem_store      (mem_store),
    .mem_load_data  (mem_load_data),
    .mem_busy       (mem_busy),
    .ext_address    (ext_address),
    .ext_write_data (ext_write_data),
    .ext_strobe     (ext_strobe),
    .ext_write      (ext_write),
    .ext_valid      (ext_valid),
    .ext_ready      (ext_ready),
    .ext_read_data  (ext_read_data)
`ifdef DATA_BUS_FAULT_EN
    ,
    .ext_error      (ext_error),
    .mem_fault      (mem_fault)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access; expectations come from plain arithmetic on the inputs.
  task automatic access(input logic [31:0] a, input logic [1:0] sz,
                        input logic sg, input logic st,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, input logic err);
    logic [31:0] exp_ld, exp_wd, lane;
    logic [3:0]  exp_sb;
    int          n, exp_n;
    int          sh;
    bit          tmo;
    tmo = (waits >= TMO);
    exp_n = tmo ? TMO : waits + 1;
    if (sz == 2'd0) begin
      sh = int'(a[1:0]) * 8;
      exp_sb = 4'(1 << a[1:0]);
      exp_wd = (wd & 32'hFF) * 32'h01010101;
      lane = (rd >> sh) & 32'hFF;
      if (sg && lane >= 32'h80) lane = lane | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      sh = a[1] ? 16 : 0;
      exp_sb = a[1] ? 4'd12 : 4'd3;
      exp_wd = (wd & 32'hFFFF) * 32'h00010001;
      lane = (rd >> sh) & 32'hFFFF;
      if (sg && lane >= 32'h8000) lane = lane | 32'hFFFF0000;
    end else begin
      exp_sb = 4'd15;
      exp_wd = wd;
      lane = rd;
    end
    if (!st) exp_sb = 4'd0;
    exp_ld = (st || tmo) ? 32'd0 : lane;

    @(posedge clk); #1;
    mem_address = a; mem_size = sz; mem_signed = sg;
    mem_store_data = wd; mem_load = !st; mem_store = st;
    #1;
    check("busy_request", {31'd0, mem_busy}, 32'd1);
    @(posedge clk); #1;
    mem_load = 1'b0; mem_store = 1'b0;
    mem_address = $urandom; mem_store_data = $urandom;
    n = 0;
    while (ext_valid === 1'b1 && n < TMO + 2) begin
      check("addr", {2'b00, ext_address}, a >> 2);
      check("strobe", {28'd0, ext_strobe}, {28'd0, exp_sb});
      check("write", {31'd0, ext_write}, {31'd0, st});
      if (st) check("wdata", ext_write_data, exp_wd);
      check("busy_req", {31'd0, mem_busy}, 32'd1);
      check("ld_outside_done", mem_load_data, 32'd0);
      if (n == waits) begin
        ext_ready = 1'b1; ext_read_data = rd;
`ifdef DATA_BUS_FAULT_EN
        ext_error = err;
`endif
      end
      @(posedge clk); #1;
      ext_ready = 1'b0; ext_read_data = $urandom;
`ifdef DATA_BUS_FAULT_EN
      ext_error = 1'b0;
`endif
      n++;
    end
    check("req_cycles", n, exp_n);
    check("done_busy", {31'd0, mem_busy}, 32'd0);
    check("done_valid", {31'd0, ext_valid}, 32'd0);
    check("done_data", mem_load_data, exp_ld);
`ifdef DATA_BUS_FAULT_EN
    check("done_fault", {31'd0, mem_fault}, {31'd0, tmo | err});
`else
    if (err) check("err_unused", 32'd0, 32'd0 & {31'd0, err});
`endif
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    rst_n = 1'b0;
    mem_address = '0; mem_store_data = '0; mem_size = 2'b11;
    mem_signed = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
    ext_ready = 1'b0; ext_read_data = '0;
`ifdef DATA_BUS_FAULT_EN
    ext_error = 1'b0;
`endif
    #12;
    check("rst_valid", {31'd0, ext_valid}, 32'd0);
    check("rst_busy", {31'd0, mem_busy}, 32'd0);
    check("rst_ld", mem_load_data, 32'd0);
    check("rst_strobe", {28'd0, ext_strobe}, 32'd0);
    rst_n = 1'b1;

    access(32'h1000, 2'd2, 1'b0, 1'b0, 32'd0, 32'hDEADBEEF, 0, 1'b0);
    access(32'h1003, 2'd0, 1'b1, 1'b0, 32'd0, 32'h80112233, 0, 1'b0);
    access(32'h1003, 2'd0, 1'b0, 1'b0, 32'd0, 32'h80112233, 1, 1'b0);
    access(32'h1002, 2'd1, 1'b1, 1'b0, 32'd0, 32'h9ABC1234, 0, 1'b0);
    access(32'h2002, 2'd1, 1'b0, 1'b1, 32'h0000ABCD, 32'h55555555, 0, 1'b0);
    access(32'h3001, 2'd0, 1'b0, 1'b1, 32'h000000A5, 32'h0, 2, 1'b0);
    access(32'h4000, 2'd2, 1'b0, 1'b0, 32'd0, 32'h12345678, 5, 1'b0);
`ifdef DATA_BUS_FAULT_EN
    access(32'h5004, 2'd2, 1'b0, 1'b0, 32'd0, 32'hCAFEF00D, 1, 1'b1);
`endif

    // Size "none" must not start a transaction.
    @(posedge clk); #1;
    mem_load = 1'b1; mem_size = 2'b11; mem_address = 32'h6000;
    #1;
    check("none_busy", {31'd0, mem_busy}, 32'd0);
    @(posedge clk); #1;
    check("none_valid", {31'd0, ext_valid}, 32'd0);
    mem_load = 1'b0;

    // Reset in the middle of a request.
    @(posedge clk); #1;
    mem_load = 1'b1; mem_size = 2'd2; mem_address = 32'h7000;
    @(posedge clk); #1;
    mem_load = 1'b0;
    check("pre_rst_valid", {31'd0, ext_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, ext_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, mem_busy}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", {31'd0, ext_valid}, 32'd0);
    check("post_rst_ld", mem_load_data, 32'd0);

    for (int i = 0; i < 24; i++) begin
      rs = 2'($urandom_range(0, 2));
      ra = $urandom;
      if (rs == 2'd1) ra[0] = 1'b0;
      if (rs == 2'd2) ra[1:0] = 2'b00;
      access(ra, rs, 1'($urandom), 1'($urandom), $urandom, $urandom,
             $urandom_range(0, 5),
`ifdef DATA_BUS_FAULT_EN
             1'($urandom_range(0, 3) == 0)
`else
             1'b0
`endif
             );
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
